// File: rtl/comp_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comp_arb_pkg
//  Description : Shared constants for the compare-datapath arbiter: FSM state
//                encoding and default sizing of the requester array and the
//                datapath latency.
//  Revision    : 1.0  initial release
// ============================================================================
package comp_arb_pkg;

    // Default sizing
    localparam int c_n_req_default  = 4;
    localparam int c_dp_lat_default = 1;

    // FSM state encoding
    localparam int              c_st_w     = 2;
    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_issue = 2'd1;
    localparam logic [c_st_w-1:0] c_st_wait  = 2'd2;
    localparam logic [c_st_w-1:0] c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/comp_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at i_ptr, wrapping past N_REQ-1 to 0, and returns
//                the first requester found as a one-hot vector and an index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import comp_arb_pkg::*;
#(
    parameter int N_REQ = c_n_req_default,
    parameter int PTR_W = $clog2(c_n_req_default)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [PTR_W-1:0] o_idx
);

    logic w_found;

    // First requester at or above the pointer, with wrap-around
    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req[(int'(i_ptr) + i) % N_REQ]) begin
                o_win[(int'(i_ptr) + i) % N_REQ] = 1'b1;
                o_idx   = PTR_W'((int'(i_ptr) + i) % N_REQ);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/comp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : comp_arbiter
//  Description : Round-robin arbiter sharing one compare/flip-flop datapath
//                between N_REQ requesters. Each operation walks
//                IDLE -> ISSUE -> WAIT (DP_LAT cycles) -> DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module comp_arbiter
    import comp_arb_pkg::*;
#(
    parameter int N_REQ  = c_n_req_default,
    parameter int DP_LAT = c_dp_lat_default
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] op,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               res_x,
    output logic               res_y,
    output logic               dp_a,
    output logic               dp_b,
    output logic               dp_c,
    output logic               dp_d,
    output logic               dp_valid,
    input  logic               dp_x,
    input  logic               dp_y
);

    localparam int c_ptr_w = $clog2(N_REQ);
    localparam int c_cnt_w = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(N_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DP_LAT - 1);

    logic [c_st_w-1:0]  r_state;
    logic [c_st_w-1:0]  w_state_nxt;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] r_idx;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_dp;
    logic               r_dp_valid;
    logic               r_res_x;
    logic               r_res_y;
    logic [N_REQ-1:0]   w_win;
    logic [c_ptr_w-1:0] w_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (c_ptr_w)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_idx (w_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (|req) w_state_nxt = c_st_issue;
            c_st_issue: w_state_nxt = c_st_wait;
            c_st_wait:  if (r_cnt == '0) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Grant, operand, wait-counter, result and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_cnt      <= '0;
            r_dp       <= '0;
            r_dp_valid <= 1'b0;
            r_res_x    <= 1'b0;
            r_res_y    <= 1'b0;
        end else begin
            r_dp_valid <= 1'b0;
            r_done     <= '0;
            case (r_state)
                c_st_idle: begin
                    // Operands go straight into the datapath registers so they
                    // are presented during ISSUE alongside dp_valid.
                    if (|req) begin
                        r_gnt      <= w_win;
                        r_idx      <= w_idx;
                        r_dp       <= op[{w_idx, 2'b00} +: 4];
                        r_dp_valid <= 1'b1;
                    end
                end
                c_st_issue: r_cnt <= c_cnt_load;
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_res_x <= dp_x;
                        r_res_y <= dp_y;
                        r_done  <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_done: begin
                    r_gnt <= '0;
                    r_ptr <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign res_x    = r_res_x;
    assign res_y    = r_res_y;
    assign dp_a     = r_dp[3];
    assign dp_b     = r_dp[2];
    assign dp_c     = r_dp[1];
    assign dp_d     = r_dp[0];
    assign dp_valid = r_dp_valid;

endmodule
`default_nettype wire

// File: tb/tb_comp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_arbiter
//  Description : Self-checking bench for comp_arbiter. One instance with
//                DP_LAT=1 runs arbitration scenarios, one with DP_LAT=3 runs
//                a latency/operand sweep. Datapath model: x=a^b, y=c&d.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comp_arbiter;

    typedef struct packed {
        logic [3:0] done;
        logic       x;
        logic       y;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] nib;
        logic [3:0] gnt;
        logic       x;
        logic       y;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT with DP_LAT = 1
    logic [3:0]  req1, gnt1, done1;
    logic [15:0] op1;
    logic        res_x1, res_y1, dpa1, dpb1, dpc1, dpd1, dpv1, dpx1, dpy1;
    logic [1:0]  p1_s1;

    comp_arbiter #(.N_REQ(4), .DP_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op(op1), .gnt(gnt1), .done(done1),
        .res_x(res_x1), .res_y(res_y1), .dp_a(dpa1), .dp_b(dpb1), .dp_c(dpc1),
        .dp_d(dpd1), .dp_valid(dpv1), .dp_x(dpx1), .dp_y(dpy1)
    );

    always @(posedge clk) p1_s1 <= {dpa1 ^ dpb1, dpc1 & dpd1};
    assign dpx1 = p1_s1[1];
    assign dpy1 = p1_s1[0];

    // DUT with DP_LAT = 3
    logic [3:0]  req3, gnt3, done3;
    logic [15:0] op3;
    logic        res_x3, res_y3, dpa3, dpb3, dpc3, dpd3, dpv3, dpx3, dpy3;
    logic [1:0]  p3_s1, p3_s2, p3_s3;

    comp_arbiter #(.N_REQ(4), .DP_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .op(op3), .gnt(gnt3), .done(done3),
        .res_x(res_x3), .res_y(res_y3), .dp_a(dpa3), .dp_b(dpb3), .dp_c(dpc3),
        .dp_d(dpd3), .dp_valid(dpv3), .dp_x(dpx3), .dp_y(dpy3)
    );

    always @(posedge clk) begin
        p3_s1 <= {dpa3 ^ dpb3, dpc3 & dpd3};
        p3_s2 <= p3_s1;
        p3_s3 <= p3_s2;
    end
    assign dpx3 = p3_s3[1];
    assign dpy3 = p3_s3[0];

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_oh0(input logic [3:0] v);
        return (v & (v - 4'd1)) == 4'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt1 onehot", {31'd0, is_oh0(gnt1)}, 32'd1);
            chk("done1 onehot", {31'd0, is_oh0(done1)}, 32'd1);
            if (done1 != 4'd0) begin
                if (q1.size() == 0) begin
                    chk("unexpected done1", {28'd0, done1}, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb done1", {28'd0, done1}, {28'd0, e1.done});
                    chk("sb res1", {30'd0, res_x1, res_y1}, {30'd0, e1.x, e1.y});
                end
            end
            if (done3 != 4'd0) begin
                if (q3.size() == 0) begin
                    chk("unexpected done3", {28'd0, done3}, 32'd0);
                end else begin
                    e3 = q3.pop_front();
                    chk("sb done3", {28'd0, done3}, {28'd0, e3.done});
                    chk("sb res3", {30'd0, res_x3, res_y3}, {30'd0, e3.x, e3.y});
                end
            end
        end
    end

    // One full DP_LAT=1 operation, starting just before the IDLE sampling edge
    task automatic serve1(input string tag, input logic [3:0] egnt, input logic [3:0] nib,
                          input logic ex, input logic ey, input logic [3:0] drop,
                          input logic [3:0] rel);
        q1.push_back(exp_t'{egnt, ex, ey});
        tick();
        chk({tag, " gnt"}, {28'd0, gnt1}, {28'd0, egnt});
        chk({tag, " dp_valid on"}, {31'd0, dpv1}, 32'd1);
        chk({tag, " dp ops"}, {28'd0, dpa1, dpb1, dpc1, dpd1}, {28'd0, nib});
        tick();
        chk({tag, " dp_valid off"}, {31'd0, dpv1}, 32'd0);
        chk({tag, " done early"}, {28'd0, done1}, 32'd0);
        chk({tag, " gnt held"}, {28'd0, gnt1}, {28'd0, egnt});
        req1 = req1 & ~drop;
        tick();
        chk({tag, " done"}, {28'd0, done1}, {28'd0, egnt});
        chk({tag, " res"}, {30'd0, res_x1, res_y1}, {30'd0, ex, ey});
        chk({tag, " dp ops held"}, {28'd0, dpa1, dpb1, dpc1, dpd1}, {28'd0, nib});
        req1 = req1 & ~rel;
        tick();
        chk({tag, " gnt clear"}, {28'd0, gnt1}, 32'd0);
        chk({tag, " done clear"}, {28'd0, done1}, 32'd0);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, " gnt"}, {28'd0, gnt1}, 32'd0);
        chk({tag, " done"}, {28'd0, done1}, 32'd0);
        chk({tag, " dp_valid"}, {31'd0, dpv1}, 32'd0);
        chk({tag, " dp ops"}, {28'd0, dpa1, dpb1, dpc1, dpd1}, 32'd0);
        chk({tag, " res"}, {30'd0, res_x1, res_y1}, 32'd0);
    endtask

    vec_t       tbl[6];
    int         order[5];
    logic [3:0] nb, m3, nib3;
    int         idx;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, 4'b1011, 4'b0001, 1'b1, 1'b1};
        tbl[1] = '{4'b0010, 4'b0110, 4'b0010, 1'b1, 1'b0};
        tbl[2] = '{4'b0100, 4'b1100, 4'b0100, 1'b0, 1'b0};
        tbl[3] = '{4'b1000, 4'b0011, 4'b1000, 1'b0, 1'b1};
        tbl[4] = '{4'b0001, 4'b1111, 4'b0001, 1'b0, 1'b1};
        tbl[5] = '{4'b1000, 4'b0101, 4'b1000, 1'b1, 1'b0};
        order  = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req1 = '0; op1 = '0; req3 = '0; op3 = '0;
        tick();
        tick();
        chk_zero1("reset");
        chk("reset gnt3", {28'd0, gnt3}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single requests from a table
        for (int k = 0; k < 6; k++) begin
            req1 = tbl[k].req;
            op1  = {4{tbl[k].nib}};
            serve1($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].nib, tbl[k].x, tbl[k].y,
                   4'b0000, tbl[k].req);
        end

        // Wrap: requester 3 was last served, so 0 wins, then 3
        req1 = 4'b1001;
        op1  = 16'h500E;
        serve1("wrap0", 4'b0001, 4'hE, 1'b0, 1'b0, 4'b0000, 4'b0000);
        serve1("wrap3", 4'b1000, 4'h5, 1'b1, 1'b0, 4'b0000, 4'b1001);

        // Full contention, held: 0,1,2,3,0 back to back
        req1 = 4'b1111;
        op1  = 16'h3A6C;
        for (int k = 0; k < 5; k++) begin
            idx = order[k];
            nb  = op1[4*idx +: 4];
            serve1($sformatf("rr%0d", k), 4'b0001 << idx, nb, nb[3] ^ nb[2], nb[1] & nb[0],
                   4'b0000, (k == 4) ? 4'b1111 : 4'b0000);
        end

        // Requester 2 drops its request during WAIT; done still pulses
        req1 = 4'b0100;
        op1  = 16'h0B00;
        serve1("drop", 4'b0100, 4'hB, 1'b1, 1'b1, 4'b0100, 4'b0000);
        req1 = 4'b0011;
        op1  = 16'h0075;
        serve1("after drop", 4'b0001, 4'h5, 1'b1, 1'b0, 4'b0000, 4'b0001);
        serve1("after drop2", 4'b0010, 4'h7, 1'b1, 1'b1, 4'b0000, 4'b0010);

        // Reset while in WAIT (pointer is 2 here)
        req1 = 4'b1000;
        op1  = 16'hF000;
        tick();
        chk("rstwait gnt", {28'd0, gnt1}, 32'h8);
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero1("async reset");
        req1 = 4'b0110;
        op1  = 16'h0090;
        tick();
        chk("in reset gnt", {28'd0, gnt1}, 32'd0);
        rst_n = 1'b1;
        serve1("post reset", 4'b0010, 4'h9, 1'b1, 1'b0, 4'b0000, 4'b0110);

        // DP_LAT=3 sweep over all operand values
        for (int v = 0; v < 16; v++) begin
            m3   = 4'b0001 << (v % 4);
            nib3 = 4'(v);
            req3 = m3;
            op3  = {4{nib3}};
            q3.push_back(exp_t'{m3, nib3[3] ^ nib3[2], nib3[1] & nib3[0]});
            tick();
            chk("lat3 gnt", {28'd0, gnt3}, {28'd0, m3});
            chk("lat3 dp_valid", {31'd0, dpv3}, 32'd1);
            chk("lat3 dp ops", {28'd0, dpa3, dpb3, dpc3, dpd3}, {28'd0, nib3});
            tick();
            chk("lat3 dp_valid off", {31'd0, dpv3}, 32'd0);
            tick();
            tick();
            chk("lat3 done early", {28'd0, done3}, 32'd0);
            tick();
            chk("lat3 done", {28'd0, done3}, {28'd0, m3});
            chk("lat3 res", {30'd0, res_x3, res_y3},
                {30'd0, nib3[3] ^ nib3[2], nib3[1] & nib3[0]});
            req3 = 4'b0000;
            tick();
            chk("lat3 done clear", {28'd0, done3}, 32'd0);
            chk("lat3 gnt clear", {28'd0, gnt3}, 32'd0);
        end

        tick();
        chk("q1 drained", q1.size(), 32'd0);
        chk("q3 drained", q3.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comp_arbiter.md
COMP_ARBITER -- requirements
Module: comp_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter DP_LAT, default 1, meaning the cycles from dp_valid to a valid dp_x/dp_y (range 1..4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, N_REQ bits: per-requester request, held until its done pulse.
REQ-006 The block SHALL have port op, input, 4*N_REQ bits: per-requester operand nibble {a,b,c,d}, with requester i at bits [4i+3:4i].
REQ-007 The block SHALL have port gnt, output, N_REQ bits: one-hot grant, held from ISSUE through DONE.
REQ-008 The block SHALL have port done, output, N_REQ bits: one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port res_x / res_y, output, 1 bit each: captured datapath result, valid while done is non-zero.
REQ-010 The block SHALL have port dp_a, dp_b, dp_c, dp_d, output, 1 bit each: registered operands driven to the shared compare/flip-flop datapath.
REQ-011 The block SHALL have port dp_valid, output, 1 bit: operands valid, one cycle per operation.
REQ-012 The block SHALL have port dp_x / dp_y, input, 1 bit each: datapath outputs.

Function
REQ-013 The block SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-014 IDLE SHALL, when any req bit is 1, pick the winner round-robin starting at pointer ptr, latch op[winner], set gnt, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-015 ISSUE SHALL assert dp_valid for exactly one cycle, drive the latched operands on dp_a..dp_d, load the wait counter with DP_LAT-1, and go to WAIT.
REQ-016 WAIT SHALL decrement the counter each cycle; at 0 it SHALL capture dp_x/dp_y into res_x/res_y and go to DONE.
REQ-017 DONE SHALL pulse done[winner] for one cycle, set ptr to (winner+1) mod N_REQ, clear gnt, and return to IDLE.
REQ-018 Latency: for req sampled in IDLE at cycle t, done SHALL assert at cycle t+DP_LAT+2; throughput SHALL be one operation per DP_LAT+3 cycles.
REQ-019 Requests arriving outside IDLE SHALL be ignored until the next IDLE cycle and never lost while held.
REQ-020 A req deasserted mid-operation SHALL NOT abort the operation; done SHALL still pulse and the result is discarded by the requester.
REQ-021 Simultaneous requests SHALL grant the lowest index at or above ptr, with wrap-around past N_REQ-1 to 0.
REQ-022 dp_a..dp_d SHALL hold their last value outside ISSUE.
REQ-023 gnt and done SHALL always be one-hot or zero.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, ptr 0, gnt 0, done 0, dp_valid 0, dp_a..dp_d 0, res_x/res_y 0, and counter 0.
REQ-025 Reset mid-operation SHALL drop the operation with no done pulse; the first request after release SHALL be arbitrated from ptr 0.

Structure
REQ-026 Package comp_arb_pkg SHALL hold the state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the N_REQ and DP_LAT defaults.
REQ-027 Sub-module rr_pick SHALL be combinational: req and ptr in, one-hot winner and index out; it SHALL be instantiated once.

Verification
REQ-028 The bench datapath model SHALL register x=a^b and y=c&d with DP_LAT=1.
REQ-029 Single request: req=0001 with op[3:0]=1011 -> gnt=0001 at t+1, dp_valid at t+1 only, done=0001 at t+3 with res_x=1 and res_y=1.
REQ-030 Contention: req=1111 held -> grant order 0,1,2,3,0, each done 4 cycles apart.
REQ-031 Wrap: after requester 3 is served, req=1001 -> requester 0 is granted.
REQ-032 Drop: requester 2 deasserts req during WAIT -> done=0100 still pulses and the next grant follows normally.
REQ-033 Reset in WAIT: rst_n pulsed low -> all outputs 0 the same cycle, no done, and the next req=0110 is granted to requester 1.
REQ-034 Latency sweep: DP_LAT=3 -> done at t+5, and res matches the model for all 16 operand values.
